// File: rtl/apb_cmd_master_pkg.sv
// ---------------------------------------------------------------------------
// apb_cmd_master_pkg
//   Shared types for the APB command master and its command FIFO.
//   - state_t : master FSM states
//   - cmd_t   : one buffered register-access command {wr, addr, wdata}
//   - CMD_ADDR_W / CMD_DATA_W mirror the top-level ADDR_WIDTH / DATA_WIDTH
//     defaults; the top-level widths must match them.
//   - TMO_CNT_W : width of the ACCESS-phase timeout counter
// ---------------------------------------------------------------------------
package apb_cmd_master_pkg;

  localparam int CMD_ADDR_W = 64;
  localparam int CMD_DATA_W = 32;

  // Wide enough for any TIMEOUT_CYCLES up to 65535.
  localparam int TMO_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  wr;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// ---------------------------------------------------------------------------
// apb_cmd_fifo
//   Synchronous FIFO of cmd_t entries with registered full/empty flags.
//   Pushes while full and pops while empty are ignored. DEPTH must be a
//   power of two (pointers wrap naturally) and at least 2.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push, din    : write strobe and entry
//   pop, dout    : read strobe and head entry (dout valid while !empty)
//   full, empty  : registered occupancy flags
// ---------------------------------------------------------------------------
module apb_cmd_fifo
  import apb_cmd_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // Flags come from the next count so they are plain flops, with no
      // combinational path from push/pop to the outputs.
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//   Accepts register-access commands on a valid/ready interface, buffers them
//   in apb_cmd_fifo and issues them one at a time as APB SETUP/ACCESS phases.
//   Each command yields exactly one response, in command order. At most one
//   APB transfer is outstanding; PSEL is low for at least the RESP cycle
//   between consecutive transfers.
//
// Build option
//   APB_CMD_MASTER_TIMEOUT_EN : when defined, an ACCESS phase that sees no
//   PREADY for TIMEOUT_CYCLES cycles is aborted and answered with
//   rsp_err=1, rsp_timeout=1, rsp_rdata=0. When undefined, ACCESS waits
//   indefinitely and rsp_timeout is constant 0.
//
// Ports
//   fsm_clk, fsm_rst        : clock (also the APB PCLK), async active-high reset
//   cmd_vld/cmd_rdy         : command handshake; cmd_rdy = !fifo_full
//   cmd_wr/addr/wdata       : command fields (wdata unused for reads)
//   rsp_vld/rsp_rdy         : response handshake
//   rsp_rdata/err/timeout   : response fields, held while rsp_vld
//   PSEL..PWDATA            : APB requester outputs
//   PREADY/PSLVERR/PRDATA   : APB completer inputs, sampled only in ACCESS
// ---------------------------------------------------------------------------
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = CMD_ADDR_W,
  parameter int DATA_WIDTH     = CMD_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  // Read data is only returned for error-free reads.
  function automatic logic [DATA_WIDTH-1:0] rsp_data_sel(
    input logic                  wr,
    input logic                  err,
    input logic [DATA_WIDTH-1:0] rdata
  );
    return (wr || err) ? '0 : rdata;
  endfunction

  state_t state_q;
  state_t state_d;

  cmd_t fifo_din;
  cmd_t fifo_dout;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;

  cmd_t                  cur_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_load;
  logic                  tmo_abort;
  logic                  tmo_expire;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_din       = '0;
    fifo_din.wr    = cmd_wr;
    fifo_din.addr  = cmd_addr;
    fifo_din.wdata = cmd_wdata;
  end

  assign cmd_rdy   = !fifo_full;
  assign fifo_push = cmd_vld && cmd_rdy;

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (fsm_clk),
    .rst   (fsm_rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // -------------------------------------------------------------------------
  // ACCESS timeout
  // -------------------------------------------------------------------------
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] tmo_cnt_q;
  logic                 rsp_tmo_q;

  // The counter is zero whenever the FSM is outside ACCESS, so it is already
  // clear on entry to SETUP. It reads 0 in the first ACCESS cycle, so a
  // match with TIMEOUT_CYCLES-1 means TIMEOUT_CYCLES cycles without PREADY.
  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_expire = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      rsp_tmo_q <= 1'b0;
    end else if (rsp_load || tmo_abort) begin
      rsp_tmo_q <= tmo_abort;
    end
  end

  assign rsp_timeout = rsp_tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYCLES;
  assign tmo_expire     = 1'b0;
  assign rsp_timeout    = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    rsp_load  = 1'b0;
    tmo_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_load = 1'b1;
          state_d  = RESP;
        end else if (tmo_expire) begin
          tmo_abort = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Current command and response registers
  // -------------------------------------------------------------------------
  // Reset as well so that every APB and response output is 0 out of reset.
  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      cur_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (fifo_pop) cur_q <= fifo_dout;
      if (rsp_load) begin
        rsp_rdata_q <= rsp_data_sel(cur_q.wr, PSLVERR, PRDATA);
        rsp_err_q   <= PSLVERR;
      end else if (tmo_abort) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  // APB controls decode straight from the state register, so an asynchronous
  // reset drops PSEL/PENABLE immediately.
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = cur_q.wr;
  assign PADDR     = cur_q.addr;
  assign PWDATA    = cur_q.wdata;

  assign rsp_vld   = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

  localparam logic [63:0] ERR_ADDR  = 64'h100;
  localparam logic [63:0] HANG_ADDR = 64'h200;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  logic        clk;
  logic        fsm_rst;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_wr;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [63:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  int n_checks = 0;
  int n_errs   = 0;

  apb_cmd_master #(
    .ADDR_WIDTH     (64),
    .DATA_WIDTH     (32),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .fsm_clk     (clk),
    .fsm_rst     (fsm_rst),
    .cmd_vld     (cmd_vld),
    .cmd_rdy     (cmd_rdy),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_vld     (rsp_vld),
    .rsp_rdy     (rsp_rdy),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .PRDATA      (PRDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- APB completer model ----------------
  logic [31:0] slv_mem [16] = '{default: 32'h0};
  int          wait_states  = 0;
  int          wcnt         = 0;

  assign PREADY  = PSEL && PENABLE && (PADDR != HANG_ADDR) && (wcnt >= wait_states);
  assign PSLVERR = PREADY && (PADDR == ERR_ADDR);
  assign PRDATA  = slv_mem[PADDR[5:2]];

  always @(posedge clk) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (PREADY && PWRITE && !PSLVERR) slv_mem[PADDR[5:2]] <= PWDATA;
  end

  // ---------------- scoreboard and APB monitor ----------------
  exp_t        sb_q[$];
  exp_t        mon_e;
  exp_t        new_e;
  logic [31:0] shadow [16] = '{default: 32'h0};
  logic        psel_q       = 1'b0;
  logic        pwrite_q     = 1'b0;
  logic [63:0] paddr_q      = '0;
  logic [31:0] pwdata_q     = '0;
  int          psel_rises   = 0;
  int          low_run      = 100;
  int          last_gap     = 0;
  int          acc_run      = 0;
  int          last_acc_len = 0;
  int          stab_viol    = 0;
  int          n_rsp        = 0;
  logic [31:0] last_prdata  = '0;

  always @(negedge clk) begin
    if (fsm_rst) begin
      sb_q.delete();
    end else begin
      if (rsp_vld && rsp_rdy) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_rdata",   64'(rsp_rdata),   64'(mon_e.rdata));
          chk("rsp_err",     64'(rsp_err),     64'(mon_e.err));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
          n_rsp++;
        end
      end
      if (cmd_vld && cmd_rdy) begin
        if (cmd_addr == HANG_ADDR) begin
          new_e = '{rdata: 32'h0, err: TMO_EN, tmo: TMO_EN};
        end else if (cmd_addr == ERR_ADDR) begin
          new_e = '{rdata: 32'h0, err: 1'b1, tmo: 1'b0};
        end else if (cmd_wr) begin
          new_e = '{rdata: 32'h0, err: 1'b0, tmo: 1'b0};
          shadow[cmd_addr[5:2]] = cmd_wdata;
        end else begin
          new_e = '{rdata: shadow[cmd_addr[5:2]], err: 1'b0, tmo: 1'b0};
        end
        sb_q.push_back(new_e);
      end
    end

    if (PSEL && psel_q) begin
      if (PADDR !== paddr_q || PWDATA !== pwdata_q || PWRITE !== pwrite_q) stab_viol++;
      if (!PENABLE) stab_viol++;
    end
    if (PSEL && !psel_q && PENABLE) stab_viol++;
    if (PENABLE && !PSEL) stab_viol++;
    if (PSEL && !psel_q) begin
      psel_rises++;
      last_gap = low_run;
    end
    if (PSEL) low_run = 0;
    else      low_run++;
    if (PENABLE) begin
      acc_run++;
    end else if (acc_run != 0) begin
      last_acc_len = acc_run;
      acc_run      = 0;
    end
    if (PREADY && !PWRITE) last_prdata = PRDATA;
    psel_q   = PSEL;
    pwrite_q = PWRITE;
    paddr_q  = PADDR;
    pwdata_q = PWDATA;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic wr, input logic [63:0] addr, input logic [31:0] wdata);
    logic acc = 1'b0;
    int   n   = 0;
    cmd_vld   = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = cmd_rdy;
      @(posedge clk);
      n++;
    end
    #1;
    cmd_vld = 1'b0;
    if (!acc) chk("cmd_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int rises0;
    int rsp0;
    int viol0;

    fsm_rst   = 1'b1;
    cmd_vld   = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_rdy   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_rdy",     64'(cmd_rdy),     64'd1);
    chk("rst_psel",        64'(PSEL),        64'd0);
    chk("rst_penable",     64'(PENABLE),     64'd0);
    chk("rst_pwrite",      64'(PWRITE),      64'd0);
    chk("rst_paddr",       PADDR,            64'd0);
    chk("rst_pwdata",      64'(PWDATA),      64'd0);
    chk("rst_rsp_vld",     64'(rsp_vld),     64'd0);
    chk("rst_rsp_rdata",   64'(rsp_rdata),   64'd0);
    chk("rst_rsp_err",     64'(rsp_err),     64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    fsm_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);

    // Write then read back
    rsp_rdy = 1'b1;
    send(1'b1, 64'h0, 32'h1234_5678);
    send(1'b0, 64'h0, $urandom);
    drain(40);
    chk("t1_prdata", 64'(last_prdata), 64'h1234_5678);

    // Same with slave wait states
    wait_states = 2;
    send(1'b1, 64'h8, 32'hA5A5_0F0F);
    send(1'b0, 64'h8, $urandom);
    send(1'b0, 64'h0, $urandom);
    drain(60);
    wait_states = 0;

    // FIFO fill with responses stalled
    rsp_rdy = 1'b0;
    rises0  = psel_rises;
    rsp0    = n_rsp;
    send(1'b1, 64'h10, 32'h0000_0010);
    send(1'b0, 64'h10, $urandom);
    send(1'b1, 64'h14, 32'h0000_0014);
    send(1'b0, 64'h14, $urandom);
    send(1'b0, 64'h0,  $urandom);
    chk("t2_cmd_rdy_full", 64'(cmd_rdy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("t2_one_psel",     64'(psel_rises - rises0), 64'd1);
    chk("t2_rsp_vld_held", 64'(rsp_vld),             64'd1);
    chk("t2_still_full",   64'(cmd_rdy),             64'd0);
    rsp_rdy = 1'b1;
    drain(100);
    chk("t2_psel_count", 64'(psel_rises - rises0), 64'd5);
    chk("t2_rsp_count",  64'(n_rsp - rsp0),        64'd5);
    chk("t2_cmd_rdy",    64'(cmd_rdy),             64'd1);

    // Slave error on a read, then a queued command still completes
    send(1'b0, ERR_ADDR, $urandom);
    send(1'b0, 64'h10, $urandom);
    send(1'b1, ERR_ADDR, 32'hDEAD_BEEF);
    send(1'b0, 64'h0, $urandom);
    drain(60);

    // Back-to-back writes
    viol0  = stab_viol;
    rises0 = psel_rises;
    send(1'b1, 64'h14, 32'hCAFE_0005);
    send(1'b1, 64'h18, 32'hCAFE_0006);
    drain(40);
    chk("t6_psel_count", 64'(psel_rises - rises0), 64'd2);
    chk("t6_gap",        64'(last_gap),            64'd1);
    chk("t6_stable",     64'(stab_viol - viol0),   64'd0);
    send(1'b0, 64'h14, $urandom);
    send(1'b0, 64'h18, $urandom);
    drain(40);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // Completer never answers
    send(1'b0, HANG_ADDR, $urandom);
    send(1'b0, 64'h18, $urandom);
    drain(80);
    chk("t4_access_len", 64'(last_acc_len), 64'd8);
`endif

    // Reset in the middle of ACCESS with commands still queued
    send(1'b0, HANG_ADDR, $urandom);
    send(1'b0, 64'h14, $urandom);
    send(1'b0, 64'h18, $urandom);
    begin
      int n = 0;
      while (!PENABLE && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("t5_in_access", 64'(PENABLE), 64'd1);
    #2;
    fsm_rst = 1'b1;
    #1;
    chk("t5_psel",    64'(PSEL),    64'd0);
    chk("t5_penable", 64'(PENABLE), 64'd0);
    chk("t5_rsp_vld", 64'(rsp_vld), 64'd0);
    @(posedge clk);
    #1;
    fsm_rst = 1'b0;
    chk("t5_cmd_rdy", 64'(cmd_rdy), 64'd1);
    rises0 = psel_rises;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_fifo_empty", 64'(psel_rises - rises0), 64'd0);
    chk("t5_no_rsp",     64'(rsp_vld),             64'd0);
    send(1'b1, 64'h1C, 32'h7777_0007);
    send(1'b0, 64'h1C, $urandom);
    drain(40);

    chk("apb_protocol", 64'(stab_viol), 64'd0);
    chk("sb_empty",     64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
